// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache-to-memory arbiter: FSM encodings, owner ids,
// line geometry and the buffered-writeback payload.
package cache_mem_arbiter_pkg;

  localparam int unsigned LINE_OFF_DEF = 4;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned BEAT_W       = 32;
  localparam int unsigned LINE_W       = 128;
  localparam int unsigned TYPE_W       = 3;
  localparam int unsigned STRB_W       = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [TYPE_W-1:0] RD_TYPE_LINE = 3'b100;

  typedef struct packed {
    logic [TYPE_W-1:0] wtype;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [LINE_W-1:0] data;
  } wb_payload_t;

  // True when a and b fall in the same cache line (offset bits ignored).
  function automatic logic same_line(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b,
                                     input int unsigned       off);
    return ((a ^ b) >> off) == '0;
  endfunction

endpackage

// File: rtl/wb_entry.sv
// Single-entry writeback buffer: accepts one victim line when empty, presents it
// downstream until accepted, and flags reads that target the buffered line.
module wb_entry
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned LINE_OFF = LINE_OFF_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_req,
  input  wb_payload_t       fill_payload,
  output logic              fill_rdy,
  output logic              drain_req,
  output wb_payload_t       drain_payload,
  input  logic              drain_rdy,
  input  logic [ADDR_W-1:0] cmp_a_addr,
  input  logic [ADDR_W-1:0] cmp_b_addr,
  output logic              hit_a,
  output logic              hit_b
);

  logic        wb_valid;
  wb_payload_t wb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
    end else if (drain_req && drain_rdy) begin
      wb_valid <= 1'b0;
    end else if (fill_req && fill_rdy) begin
      wb_valid <= 1'b1;
    end
  end

  // Payload needs no reset; it is only observed while wb_valid is set.
  always_ff @(posedge clk) begin
    if (fill_req && fill_rdy) begin
      wb_q <= fill_payload;
    end
  end

  assign fill_rdy      = !wb_valid;
  assign drain_req     = wb_valid;
  assign drain_payload = wb_q;
  assign hit_a         = wb_valid && same_line(cmp_a_addr, wb_q.addr, LINE_OFF);
  assign hit_b         = wb_valid && same_line(cmp_b_addr, wb_q.addr, LINE_OFF);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the memory read/write port between icache and dcache: round-robin line
// refills (one outstanding) plus an independent one-entry dcache writeback path.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned LINE_OFF = LINE_OFF_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rd_req,
  input  logic [TYPE_W-1:0] i_rd_type,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              i_rd_rdy,
  output logic              i_ret_valid,
  output logic              i_ret_last,
  output logic [BEAT_W-1:0] i_ret_data,
  input  logic              d_rd_req,
  input  logic [TYPE_W-1:0] d_rd_type,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic              d_rd_rdy,
  output logic              d_ret_valid,
  output logic              d_ret_last,
  output logic [BEAT_W-1:0] d_ret_data,
  input  logic              d_wr_req,
  input  logic [TYPE_W-1:0] d_wr_type,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [STRB_W-1:0] d_wr_wstrb,
  input  logic [LINE_W-1:0] d_wr_data,
  output logic              d_wr_rdy,
  output logic              m_rd_req,
  output logic [TYPE_W-1:0] m_rd_type,
  output logic [ADDR_W-1:0] m_rd_addr,
  input  logic              m_rd_rdy,
  input  logic              m_ret_valid,
  input  logic              m_ret_last,
  input  logic [BEAT_W-1:0] m_ret_data,
  output logic              m_wr_req,
  output logic [TYPE_W-1:0] m_wr_type,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [STRB_W-1:0] m_wr_wstrb,
  output logic [LINE_W-1:0] m_wr_data,
  input  logic              m_wr_rdy
);

  logic [1:0]  state, state_nx;
  logic        owner, owner_nx;
  logic        last_grant, last_grant_nx;
  logic        i_hit, d_hit, i_elig, d_elig;
  logic        own_req, in_req, in_resp;
  wb_payload_t wr_payload, wb_out;

  assign wr_payload = '{wtype: d_wr_type, addr: d_wr_addr, wstrb: d_wr_wstrb, data: d_wr_data};

  wb_entry #(.LINE_OFF(LINE_OFF)) u_wb (
    .clk          (clk),
    .reset        (reset),
    .fill_req     (d_wr_req),
    .fill_payload (wr_payload),
    .fill_rdy     (d_wr_rdy),
    .drain_req    (m_wr_req),
    .drain_payload(wb_out),
    .drain_rdy    (m_wr_rdy),
    .cmp_a_addr   (i_rd_addr),
    .cmp_b_addr   (d_rd_addr),
    .hit_a        (i_hit),
    .hit_b        (d_hit)
  );

  assign m_wr_type  = wb_out.wtype;
  assign m_wr_addr  = wb_out.addr;
  assign m_wr_wstrb = wb_out.wstrb;
  assign m_wr_data  = wb_out.data;

  // A read to the line sitting in the write buffer waits until it drains.
  assign i_elig  = i_rd_req && !i_hit;
  assign d_elig  = d_rd_req && !d_hit;
  assign in_req  = (state == ST_REQ);
  assign in_resp = (state == ST_RESP);
  assign own_req = (owner == OWN_D) ? d_rd_req : i_rd_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_I;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    case (state)
      ST_IDLE: begin
        if (i_elig || d_elig) begin
          if (i_elig && d_elig) owner_nx = ~last_grant;
          else                  owner_nx = d_elig ? OWN_D : OWN_I;
          last_grant_nx = owner_nx;
          state_nx      = ST_REQ;
        end
      end
      ST_REQ:  if (own_req && m_rd_rdy)       state_nx = ST_RESP;
      ST_RESP: if (m_ret_valid && m_ret_last) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign m_rd_req  = in_req && own_req;
  assign m_rd_type = (owner == OWN_D) ? d_rd_type : i_rd_type;
  assign m_rd_addr = (owner == OWN_D) ? d_rd_addr : i_rd_addr;

  assign i_rd_rdy = in_req && (owner == OWN_I) && m_rd_rdy;
  assign d_rd_rdy = in_req && (owner == OWN_D) && m_rd_rdy;

  // Beats go only to the owner; data is broadcast since valid qualifies it.
  assign i_ret_valid = in_resp && (owner == OWN_I) && m_ret_valid;
  assign i_ret_last  = in_resp && (owner == OWN_I) && m_ret_last;
  assign d_ret_valid = in_resp && (owner == OWN_D) && m_ret_valid;
  assign d_ret_last  = in_resp && (owner == OWN_D) && m_ret_last;
  assign i_ret_data  = m_ret_data;
  assign d_ret_data  = m_ret_data;

endmodule
